refill_issue_arbiter: RTL and testbench
=======================================

# refill_issue_arbiter

Shares the single refill-issue path to the memory controller among the per-bank HTU miss requesters. Grants one request per cycle (round-robin), allocates a ROB id from a free pool of `Cfg.robSize` entries, registers the request towards memctl and pulses the `htu_refill_*` mark into `inflight_array`. ROB ids return to the pool when memctl reports refill completion.

## Interface
- `Cfg`, default `mpcBuildConfig` of the standard user config (robSize 8, banks 4): cache configuration.
- `NumReq`, default `Cfg.banks`: number of requesters.
- `setWidth_t`, `wayIndexWidth_t`, `nlineWidth_t`, `robWidth_t`, defaults from `Cfg`: field types.
- `clk`  in  1  clock, single domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `htu_req_valid`  in  NumReq  per-requester refill request.
- `htu_req_set`  in  NumReq×setWidth  set of request.
- `htu_req_way`  in  NumReq×wayIndexWidth  victim way of request.
- `htu_req_ready`  out  NumReq  grant; request consumed when valid&ready.
- `htu_refill_valid`  out  1  one-cycle mark pulse to inflight_array.
- `htu_refill_set` / `htu_refill_way`  out  setWidth / wayIndexWidth  mark location.
- `memctl_req_valid`  out  1  refill request to memctl.
- `memctl_req_ready`  in  1  memctl accepts.
- `memctl_req_id`  out  nlineWidth  `{way,set}` line id.
- `memctl_req_rob`  out  robWidth  allocated ROB id.
- `memctl_refill_valid`  in  1  refill done.
- `memctl_refill_rob`  in  robWidth  ROB id being returned.
- `outstanding_cnt`  out  robWidth+1  allocated ROB ids.
- `arb_err`  out  1  sticky: free of an unallocated id.

## Operation
- State: output register (valid, set, way, rob), ROB free bitmap (robSize bits), outstanding counter, RR pointer, `arb_err`.
- FSM on output register: IDLE (empty) -> HOLD on grant; HOLD -> IDLE on `memctl_req_ready` with no new grant; HOLD -> HOLD on ready plus new grant (back-to-back); HOLD -> HOLD while not ready (payload stable).
- Grant condition: output register empty or draining this cycle (`memctl_req_ready`), AND at least one free ROB id in the *registered* bitmap.
- Arbitration: round-robin starting at pointer; after a grant, pointer = granted index + 1 (mod NumReq). At most one `htu_req_ready` high per cycle; ready is low for all when the grant condition fails.
- Allocation: lowest-index free ROB id; bitmap bit cleared, counter +1.
- Free: on `memctl_refill_valid`, bit `memctl_refill_rob` set, counter −1. If the bit was already free: no change, `arb_err` set (sticky until reset).
- Simultaneous alloc and free: counter unchanged; freed id not allocatable until next cycle.
- Counter saturates at robSize; ready never asserted at robSize.

## Timing
- Reset: all outputs 0, bitmap all free, pointer 0, FSM IDLE.
- Grant in cycle T (combinational ready) -> `memctl_req_valid`, `memctl_req_id`, `memctl_req_rob`, and one-cycle `htu_refill_valid/set/way` in T+1.
- `htu_refill_valid` pulses once per grant, regardless of memctl backpressure.
- Sustained throughput one grant per cycle with `memctl_req_ready` held high and free ids.
- Reset mid-operation: outstanding ids discarded, in-flight memctl request dropped.

## Configuration
- `MPC_REFILL_ARB_FIXPRIO_EN`: defined -> fixed priority, lowest requester index wins, pointer logic removed. Undefined -> round-robin as above.

## Structure
- `mpc_types` gains `mpc_refill_req_t` (set, way, rob) and helper `mpcLineId(way,set)` returning `{way,set}`.
- One sub-module: `mpc_rr_arb` (NumReq requests, enable, grant one-hot, pointer update; fixed-priority variant under the macro).

## Test plan
- Reset then single request: req 1, set 2, way 3 at T -> T+1 `memctl_req_id`={2'd3,3'd2}, rob 0, `htu_refill_valid` pulse.
- All 4 requesters valid, ready high -> grants 0,1,2,3,0 on consecutive cycles; robs 0,1,2,3,4.
- 8 grants without frees -> `outstanding_cnt`=8, all ready low; free rob 5 -> next cycle grant receives rob 5.
- `memctl_req_ready` low 3 cycles -> payload stable, no further grants, one `htu_refill_valid` pulse only.
- Free rob 2 twice -> second free sets `arb_err`, counter unaffected.
- With `MPC_REFILL_ARB_FIXPRIO_EN`, requesters 0 and 2 held valid -> requester 0 granted every cycle.

Source files
------------

// File: rtl/refill_issue_arbiter_pkg.sv
// rtl/refill_issue_arbiter_pkg.sv - shared config, field types and helpers for the refill-issue arbiter
package refill_issue_arbiter_pkg;

    typedef struct packed {
        int unsigned robSize;
        int unsigned banks;
        int unsigned sets;
        int unsigned ways;
    } mpc_cfg_t;

    function automatic mpc_cfg_t mpcBuildConfig();
        mpc_cfg_t c;
        c.robSize = 8;
        c.banks   = 4;
        c.sets    = 8;
        c.ways    = 4;
        return c;
    endfunction

    localparam mpc_cfg_t    MPC_DEFAULT_CFG = mpcBuildConfig();
    localparam int unsigned MPC_SET_W       = $clog2(MPC_DEFAULT_CFG.sets);
    localparam int unsigned MPC_WAY_W       = $clog2(MPC_DEFAULT_CFG.ways);
    localparam int unsigned MPC_ROB_W       = $clog2(MPC_DEFAULT_CFG.robSize);

    typedef logic [MPC_SET_W-1:0]           mpc_set_t;
    typedef logic [MPC_WAY_W-1:0]           mpc_way_t;
    typedef logic [MPC_ROB_W-1:0]           mpc_rob_t;
    typedef logic [MPC_WAY_W+MPC_SET_W-1:0] mpc_nline_t;

    typedef struct packed {
        mpc_set_t set;
        mpc_way_t way;
        mpc_rob_t rob;
    } mpc_refill_req_t;

    function automatic mpc_nline_t mpcLineId(input mpc_way_t way, input mpc_set_t set);
        return {way, set};
    endfunction

endpackage

// File: rtl/refill_issue_arbiter_rr_arb.sv
// rtl/refill_issue_arbiter_rr_arb.sv - one-of-N request arbiter; MPC_REFILL_ARB_FIXPRIO_EN selects fixed priority
module mpc_rr_arb #(
    parameter  int unsigned NumReq = 4,
    localparam int unsigned IDX_W  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NumReq-1:0] i_req,
    input  logic              i_en,
    output logic [NumReq-1:0] o_grant,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

`ifdef MPC_REFILL_ARB_FIXPRIO_EN
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst_n;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (i_en && i_req[i]) begin
                o_idx = IDX_W'(i);
                o_any = 1'b1;
            end
        end
        if (o_any) o_grant[o_idx] = 1'b1;
    end
`else
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_j;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int unsigned b);
        int unsigned s;
        s = (32'(a) + b) % NumReq;
        return s[IDX_W-1:0];
    endfunction

    // Scan from farthest to nearest so the requester closest to r_ptr wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            w_j = wrap_add(r_ptr, k);
            if (i_en && i_req[w_j]) begin
                o_idx = w_j;
                o_any = 1'b1;
            end
        end
        if (o_any) o_grant[o_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (o_any) begin
            r_ptr <= wrap_add(o_idx, 1);
        end
    end
`endif

endmodule

// File: rtl/refill_issue_arbiter.sv
// rtl/refill_issue_arbiter.sv - grants HTU refill requests, allocates ROB ids and issues to memctl (MPC_REFILL_ARB_FIXPRIO_EN: fixed priority)
module refill_issue_arbiter
    import refill_issue_arbiter_pkg::*;
#(
    parameter mpc_cfg_t    Cfg             = mpcBuildConfig(),
    parameter int unsigned NumReq          = Cfg.banks,
    parameter type         setWidth_t      = mpc_set_t,
    parameter type         wayIndexWidth_t = mpc_way_t,
    parameter type         nlineWidth_t    = mpc_nline_t,
    parameter type         robWidth_t      = mpc_rob_t
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic           [NumReq-1:0]   htu_req_valid,
    input  setWidth_t      [NumReq-1:0]   htu_req_set,
    input  wayIndexWidth_t [NumReq-1:0]   htu_req_way,
    output logic           [NumReq-1:0]   htu_req_ready,
    output logic                          htu_refill_valid,
    output setWidth_t                     htu_refill_set,
    output wayIndexWidth_t                htu_refill_way,
    output logic                          memctl_req_valid,
    input  logic                          memctl_req_ready,
    output nlineWidth_t                   memctl_req_id,
    output robWidth_t                     memctl_req_rob,
    input  logic                          memctl_refill_valid,
    input  robWidth_t                     memctl_refill_rob,
    output logic [$bits(robWidth_t):0]    outstanding_cnt,
    output logic                          arb_err
);

    localparam int unsigned ROB_SIZE = Cfg.robSize;
    localparam int unsigned CNT_W    = $bits(robWidth_t) + 1;
    localparam int unsigned IDX_W    = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    state_t              r_state;
    mpc_refill_req_t     r_req;
    logic                r_mark;
    logic [ROB_SIZE-1:0] r_free;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;

    logic                w_can_grant;
    logic                w_any_grant;
    logic [NumReq-1:0]   w_grant;
    logic [IDX_W-1:0]    w_gnt_idx;
    robWidth_t           w_alloc_rob;
    logic                w_free_ok;

    always_comb begin
        w_alloc_rob = '0;
        for (int i = ROB_SIZE - 1; i >= 0; i--) begin
            if (r_free[i]) w_alloc_rob = robWidth_t'(i);
        end
    end

    // Allocation looks only at the registered bitmap, so an id freed this
    // cycle becomes grantable one cycle later.
    assign w_can_grant = rst_n
                      && ((r_state == ST_IDLE) || memctl_req_ready)
                      && (|r_free)
                      && (r_cnt < CNT_W'(ROB_SIZE));
    assign w_free_ok   = memctl_refill_valid && !r_free[memctl_refill_rob];

    mpc_rr_arb #(.NumReq(NumReq)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (htu_req_valid),
        .i_en    (w_can_grant),
        .o_grant (w_grant),
        .o_idx   (w_gnt_idx),
        .o_any   (w_any_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_req   <= '0;
            r_mark  <= 1'b0;
            r_free  <= '1;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_mark <= w_any_grant;
            if (w_any_grant) begin
                r_state   <= ST_HOLD;
                r_req.set <= htu_req_set[w_gnt_idx];
                r_req.way <= htu_req_way[w_gnt_idx];
                r_req.rob <= w_alloc_rob;
            end else if ((r_state == ST_HOLD) && memctl_req_ready) begin
                r_state <= ST_IDLE;
            end

            if (w_any_grant) r_free[w_alloc_rob]       <= 1'b0;
            if (w_free_ok)   r_free[memctl_refill_rob] <= 1'b1;
            if (memctl_refill_valid && !w_free_ok) r_err <= 1'b1;

            case ({w_any_grant, w_free_ok})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign htu_req_ready    = w_grant;
    assign htu_refill_valid = r_mark;
    assign htu_refill_set   = r_req.set;
    assign htu_refill_way   = r_req.way;
    assign memctl_req_valid = (r_state == ST_HOLD);
    assign memctl_req_id    = mpcLineId(r_req.way, r_req.set);
    assign memctl_req_rob   = r_req.rob;
    assign outstanding_cnt  = r_cnt;
    assign arb_err          = r_err;

endmodule

// File: tb/tb_refill_issue_arbiter.sv
// tb/tb_refill_issue_arbiter.sv - directed self-checking bench for refill_issue_arbiter
module tb_refill_issue_arbiter;
    import refill_issue_arbiter_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic       [3:0] htu_req_valid;
    mpc_set_t   [3:0] htu_req_set;
    mpc_way_t   [3:0] htu_req_way;
    logic       [3:0] htu_req_ready;
    logic             htu_refill_valid;
    mpc_set_t         htu_refill_set;
    mpc_way_t         htu_refill_way;
    logic             memctl_req_valid;
    logic             memctl_req_ready;
    mpc_nline_t       memctl_req_id;
    mpc_rob_t         memctl_req_rob;
    logic             memctl_refill_valid;
    mpc_rob_t         memctl_refill_rob;
    logic       [3:0] outstanding_cnt;
    logic             arb_err;

    int n_pass  = 0;
    int n_total = 0;
    mpc_nline_t exp_id;

    always #5 clk = ~clk;

    refill_issue_arbiter dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .htu_req_valid       (htu_req_valid),
        .htu_req_set         (htu_req_set),
        .htu_req_way         (htu_req_way),
        .htu_req_ready       (htu_req_ready),
        .htu_refill_valid    (htu_refill_valid),
        .htu_refill_set      (htu_refill_set),
        .htu_refill_way      (htu_refill_way),
        .memctl_req_valid    (memctl_req_valid),
        .memctl_req_ready    (memctl_req_ready),
        .memctl_req_id       (memctl_req_id),
        .memctl_req_rob      (memctl_req_rob),
        .memctl_refill_valid (memctl_refill_valid),
        .memctl_refill_rob   (memctl_refill_rob),
        .outstanding_cnt     (outstanding_cnt),
        .arb_err             (arb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n               = 1'b0;
        htu_req_valid       = 4'hF;
        htu_req_set         = '0;
        htu_req_way         = '0;
        memctl_req_ready    = 1'b1;
        memctl_refill_valid = 1'b0;
        memctl_refill_rob   = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",     htu_req_ready,    4'b0000);
        check("rst_mreq_vld",  memctl_req_valid, 0);
        check("rst_mark",      htu_refill_valid, 0);
        check("rst_id",        memctl_req_id,    0);
        check("rst_rob",       memctl_req_rob,   0);
        check("rst_cnt",       outstanding_cnt,  0);
        check("rst_err",       arb_err,          0);

        // Single request: requester 1, set 2, way 3
        rst_n          = 1'b1;
        htu_req_valid  = 4'b0010;
        htu_req_set[1] = 3'd2;
        htu_req_way[1] = 2'd3;
        #1;
        check("single_ready", htu_req_ready, 4'b0010);
        tick();
        htu_req_valid = 4'b0000;
        check("single_mvld",  memctl_req_valid, 1);
        check("single_id",    memctl_req_id,    5'b11010);
        check("single_rob",   memctl_req_rob,   0);
        check("single_mark",  htu_refill_valid, 1);
        check("single_mset",  htu_refill_set,   2);
        check("single_mway",  htu_refill_way,   3);
        check("single_cnt",   outstanding_cnt,  1);
        tick();
        check("single_drain", memctl_req_valid, 0);
        check("single_pulse", htu_refill_valid, 0);
        memctl_refill_valid = 1'b1;
        memctl_refill_rob   = 3'd0;
        tick();
        memctl_refill_valid = 1'b0;
        check("single_free_cnt", outstanding_cnt, 0);
        check("single_free_err", arb_err,         0);

        // Round-robin over all four requesters until the pool is exhausted
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            htu_req_set[i] = mpc_set_t'(i);
            htu_req_way[i] = mpc_way_t'(i);
        end
        htu_req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("rr_ready_%0d", k), htu_req_ready, 32'(1) << (k % 4));
            tick();
            exp_id = {mpc_way_t'(k % 4), mpc_set_t'(k % 4)};
            check($sformatf("rr_rob_%0d", k),  memctl_req_rob,   k);
            check($sformatf("rr_id_%0d", k),   memctl_req_id,    exp_id);
            check($sformatf("rr_mark_%0d", k), htu_refill_valid, 1);
        end
        check("full_cnt", outstanding_cnt, 8);
        #1;
        check("full_ready", htu_req_ready, 4'b0000);
        memctl_refill_valid = 1'b1;
        memctl_refill_rob   = 3'd5;
        #1;
        check("free_same_cycle_ready", htu_req_ready, 4'b0000);
        tick();
        memctl_refill_valid = 1'b0;
        check("free5_cnt", outstanding_cnt, 7);
        #1;
        check("free5_ready", htu_req_ready, 4'b0001);
        tick();
        htu_req_valid = 4'b0000;
        check("realloc_rob", memctl_req_rob,  5);
        check("realloc_id",  memctl_req_id,   0);
        check("realloc_cnt", outstanding_cnt, 8);

        // Backpressure from memctl
        for (int r = 0; r < 4; r++) begin
            memctl_refill_valid = 1'b1;
            memctl_refill_rob   = mpc_rob_t'(r);
            tick();
        end
        memctl_refill_valid = 1'b0;
        check("bp_pre_cnt", outstanding_cnt, 4);
        memctl_req_ready = 1'b0;
        htu_req_valid    = 4'b0100;
        #1;
        check("bp_grant", htu_req_ready, 4'b0100);
        tick();
        htu_req_valid = 4'b0011;
        check("bp_mvld", memctl_req_valid, 1);
        check("bp_rob",  memctl_req_rob,   0);
        check("bp_id",   memctl_req_id,    5'b10010);
        check("bp_mark", htu_refill_valid, 1);
        #1;
        check("bp_noready", htu_req_ready, 4'b0000);
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("bp_hold_mark_%0d", c),  htu_refill_valid, 0);
            check($sformatf("bp_hold_mvld_%0d", c),  memctl_req_valid, 1);
            check($sformatf("bp_hold_rob_%0d", c),   memctl_req_rob,   0);
            check($sformatf("bp_hold_id_%0d", c),    memctl_req_id,    5'b10010);
            check($sformatf("bp_hold_ready_%0d", c), htu_req_ready,    4'b0000);
        end
        memctl_req_ready = 1'b1;
        #1;
        check("bp_release_ready", htu_req_ready, 4'b0001);
        tick();
        htu_req_valid = 4'b0000;
        check("bp_b2b_rob",  memctl_req_rob,   1);
        check("bp_b2b_mark", htu_refill_valid, 1);
        check("bp_b2b_cnt",  outstanding_cnt,  6);
        tick();
        check("bp_idle", memctl_req_valid, 0);

        // Double free of rob 2
        htu_req_valid = 4'b0001;
        #1;
        check("df_ready", htu_req_ready, 4'b0001);
        tick();
        htu_req_valid = 4'b0000;
        check("df_alloc_rob", memctl_req_rob,  2);
        check("df_alloc_cnt", outstanding_cnt, 7);
        memctl_refill_valid = 1'b1;
        memctl_refill_rob   = 3'd2;
        tick();
        check("df_first_cnt", outstanding_cnt, 6);
        check("df_first_err", arb_err,         0);
        tick();
        memctl_refill_valid = 1'b0;
        check("df_second_err", arb_err,         1);
        check("df_second_cnt", outstanding_cnt, 6);
        tick();
        check("df_err_sticky", arb_err, 1);

        // Reset while a request is in flight
        htu_req_valid = 4'hF;
        tick();
        check("mid_pre_mvld", memctl_req_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_mvld",  memctl_req_valid, 0);
        check("mid_id",    memctl_req_id,    0);
        check("mid_cnt",   outstanding_cnt,  0);
        check("mid_err",   arb_err,          0);
        check("mid_ready", htu_req_ready,    4'b0000);

        // Requesters 0 and 2 held valid after reset
        rst_n         = 1'b1;
        htu_req_valid = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            #1;
`ifdef MPC_REFILL_ARB_FIXPRIO_EN
            check($sformatf("pair_ready_%0d", k), htu_req_ready, 4'b0001);
`else
            check($sformatf("pair_ready_%0d", k), htu_req_ready, (k % 2 == 0) ? 4'b0001 : 4'b0100);
`endif
            tick();
            check($sformatf("pair_rob_%0d", k), memctl_req_rob, k);
        end
        htu_req_valid = 4'b0000;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
